// File: rtl/fir_pkg.sv
// Shared types and default widths for the FIR frame sequencer.
// Frame flush behaviour is selected by the FIR_SEQ_FLUSH_EN macro in fir_seq.
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    DRAIN,
    DONE
  } fir_seq_state_t;

  localparam int FIR_DW   = 8;
  localparam int FIR_YW   = 19;
  localparam int FIR_TAPS = 8;

endpackage

// File: rtl/fir_seq.sv
// Frame sequencer feeding the FIR datapath and forwarding its results with a last marker.
// Define FIR_SEQ_FLUSH_EN to append TAPS-1 zero samples and return the full convolution.
module fir_seq
  import fir_pkg::*;
#(
  parameter int TAPS  = FIR_TAPS,
  parameter int DW    = FIR_DW,
  parameter int YW    = FIR_YW,
  parameter int LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             busy,
  output logic             done,
  input  logic             s_valid,
  input  logic [DW-1:0]    s_data,
  output logic             s_ready,
  output logic             fir_valid_in,
  output logic [DW-1:0]    fir_x,
  input  logic [YW-1:0]    fir_y,
  input  logic             fir_valid_out,
  output logic             m_valid,
  output logic [YW-1:0]    m_data,
  output logic             m_last
);

`ifdef FIR_SEQ_FLUSH_EN
  localparam int FLUSH_LEN = TAPS - 1;
  localparam logic [LEN_W-1:0] FLUSH_LAST = LEN_W'(FLUSH_LEN - 1);
`else
  localparam int FLUSH_LEN = 0;
`endif
  localparam logic [LEN_W:0] TOTAL_ADD = (LEN_W+1)'(FLUSH_LEN);
  localparam logic [LEN_W:0] CNT_ONE   = (LEN_W+1)'(1);

  fir_seq_state_t   state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] in_cnt_q, in_cnt_d;
  logic [LEN_W:0]   out_cnt_q, out_cnt_d;
`ifdef FIR_SEQ_FLUSH_EN
  logic [LEN_W-1:0] flush_cnt_q, flush_cnt_d;
`endif
  logic             done_q, done_d;
  logic             fir_valid_in_q, fir_valid_in_d;
  logic [DW-1:0]    fir_x_q, fir_x_d;
  logic             m_valid_q, m_valid_d;
  logic [YW-1:0]    m_data_q, m_data_d;
  logic             m_last_q, m_last_d;

  logic [LEN_W:0]   total;
  logic             last_out;
  logic             in_frame;

  // Wide enough that len + TAPS - 1 never wraps.
  assign total    = {1'b0, len_q} + TOTAL_ADD;
  assign last_out = (out_cnt_q == total - CNT_ONE);
  assign in_frame = (state_q == LOAD) || (state_q == FLUSH) || (state_q == DRAIN);

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    in_cnt_d       = in_cnt_q;
    out_cnt_d      = out_cnt_q;
`ifdef FIR_SEQ_FLUSH_EN
    flush_cnt_d    = flush_cnt_q;
`endif
    done_d         = 1'b0;
    fir_valid_in_d = 1'b0;
    fir_x_d        = '0;
    m_valid_d      = 1'b0;
    m_data_d       = m_data_q;
    m_last_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            len_d     = frame_len;
            in_cnt_d  = '0;
            out_cnt_d = '0;
`ifdef FIR_SEQ_FLUSH_EN
            flush_cnt_d = '0;
`endif
            state_d   = LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (s_valid) begin
          fir_valid_in_d = 1'b1;
          fir_x_d        = s_data;
          in_cnt_d       = in_cnt_q + 1'b1;
          if (in_cnt_q == len_q - 1'b1) begin
`ifdef FIR_SEQ_FLUSH_EN
            state_d = (FLUSH_LEN > 0) ? FLUSH : DRAIN;
`else
            state_d = DRAIN;
`endif
          end
        end
      end
`ifdef FIR_SEQ_FLUSH_EN
      FLUSH: begin
        fir_valid_in_d = 1'b1;
        flush_cnt_d    = flush_cnt_q + 1'b1;
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = DRAIN;
        end
      end
`endif
      DRAIN: begin
        state_d = state_q;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Results are counted in every active state, so the final one wins over LOAD/FLUSH moves.
    if (fir_valid_out && in_frame) begin
      m_valid_d = 1'b1;
      m_data_d  = fir_y;
      out_cnt_d = out_cnt_q + CNT_ONE;
      if (last_out) begin
        m_last_d = 1'b1;
        state_d  = DONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      len_q          <= '0;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
`ifdef FIR_SEQ_FLUSH_EN
      flush_cnt_q    <= '0;
`endif
      done_q         <= 1'b0;
      fir_valid_in_q <= 1'b0;
      fir_x_q        <= '0;
      m_valid_q      <= 1'b0;
      m_data_q       <= '0;
      m_last_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      in_cnt_q       <= in_cnt_d;
      out_cnt_q      <= out_cnt_d;
`ifdef FIR_SEQ_FLUSH_EN
      flush_cnt_q    <= flush_cnt_d;
`endif
      done_q         <= done_d;
      fir_valid_in_q <= fir_valid_in_d;
      fir_x_q        <= fir_x_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      m_last_q       <= m_last_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign s_ready      = (state_q == LOAD);
  assign done         = done_q;
  assign fir_valid_in = fir_valid_in_q;
  assign fir_x        = fir_x_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_last       = m_last_q;

endmodule

// File: tb/tb_fir_seq.sv
// Bench for fir_seq driving a behavioural FIR stand-in; expected results come from a
// convolution over the whole sample history. Honours FIR_SEQ_FLUSH_EN like the design.
module tb_fir_seq;
  import fir_pkg::*;

  localparam int TAPS  = FIR_TAPS;
  localparam int DW    = FIR_DW;
  localparam int YW    = FIR_YW;
  localparam int LEN_W = 8;
`ifdef FIR_SEQ_FLUSH_EN
  localparam int FLUSH_LEN = TAPS - 1;
`else
  localparam int FLUSH_LEN = 0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic             busy, done, s_ready;
  logic             s_valid = 1'b0;
  logic [DW-1:0]    s_data = '0;
  logic             fir_valid_in;
  logic [DW-1:0]    fir_x;
  logic [YW-1:0]    fir_y;
  logic             fir_valid_out;
  logic             m_valid, m_last;
  logic [YW-1:0]    m_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  fir_seq #(.TAPS(TAPS), .DW(DW), .YW(YW), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset), .start(start), .frame_len(frame_len),
    .busy(busy), .done(done), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fir_valid_in(fir_valid_in), .fir_x(fir_x), .fir_y(fir_y),
    .fir_valid_out(fir_valid_out), .m_valid(m_valid), .m_data(m_data), .m_last(m_last)
  );

  // FIR stand-in: coefficients k+1, one cycle of latency, delay line held across frames.
  logic [DW-1:0] dl [TAPS-1];
  int mac_i;
  always_comb begin
    mac_i = int'(fir_x);
    for (int k = 1; k < TAPS; k++) mac_i += (k + 1) * int'(dl[k-1]);
  end
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS - 1; i++) dl[i] <= '0;
      fir_valid_out <= 1'b0;
      fir_y         <= '0;
    end else begin
      fir_valid_out <= fir_valid_in;
      if (fir_valid_in) begin
        fir_y <= YW'(mac_i);
        dl[0] <= fir_x;
        for (int i = 1; i < TAPS - 1; i++) dl[i] <= dl[i-1];
      end
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int sent_q[$], sent_cyc[$], out_q[$], last_idx[$], last_cyc[$], done_cyc[$], done_busy[$];
  always @(negedge clock) begin
    if (fir_valid_in) begin
      sent_q.push_back(int'(fir_x));
      sent_cyc.push_back(cyc);
    end
    if (m_valid) begin
      out_q.push_back(int'(m_data));
      if (m_last) begin
        last_idx.push_back(out_q.size() - 1);
        last_cyc.push_back(cyc);
      end
    end
    if (done) begin
      done_cyc.push_back(cyc);
      done_busy.push_back(int'(busy));
    end
  end

  int hist[$];
  int exp_in_q[$], exp_out_q[$];

  function automatic int ref_y(input int n);
    int acc = 0;
    for (int k = 0; k < TAPS; k++) if (n - k >= 0) acc += (k + 1) * hist[n-k];
    return acc;
  endfunction

  function automatic int first_diff(input int a[$], input int b[$]);
    int m = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < m; i++) if (a[i] != b[i]) return i;
    return (a.size() == b.size()) ? -1 : m;
  endfunction

  task automatic clear_mon();
    sent_q.delete(); sent_cyc.delete(); out_q.delete();
    last_idx.delete(); last_cyc.delete(); done_cyc.delete(); done_busy.delete();
  endtask

  // Drives one frame; returns #1 after the edge that took the last sample.
  task automatic drive_frame(input int len, input bit gaps, input bit extra_start, input bit ramp);
    int data[$];
    int i, guard;
    bit xfer, ph;
    clear_mon();
    exp_in_q.delete(); exp_out_q.delete();
    for (int k = 0; k < len; k++) data.push_back(ramp ? k + 1 : int'($urandom_range(1, 255)));
    exp_in_q = data;
    for (int k = 0; k < FLUSH_LEN; k++) exp_in_q.push_back(0);
    foreach (exp_in_q[k]) begin
      hist.push_back(exp_in_q[k]);
      exp_out_q.push_back(ref_y(hist.size() - 1));
    end
    @(posedge clock); #1;
    start = 1'b1; frame_len = LEN_W'(len);
    @(posedge clock); #1;
    start = 1'b0;
    i = 0; guard = 0; ph = 1'b1;
    while (i < len && guard < 4 * len + 20) begin
      s_valid = gaps ? ph : 1'b1;
      ph = !ph;
      s_data = DW'(data[i]);
      if (extra_start && i == 2) begin
        start = 1'b1; frame_len = LEN_W'(3);
      end
      xfer = s_valid && s_ready;
      @(posedge clock); #1;
      start = 1'b0;
      if (xfer) i++;
      guard++;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    int c = 0;
    while (done_cyc.size() == 0 && c < maxc) begin
      @(posedge clock);
      c++;
    end
    ok = (done_cyc.size() != 0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({busy, done, s_ready, fir_valid_in, m_valid, m_last} !== 6'b0 || fir_x !== '0 || m_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%0b done=%0b s_ready=%0b fvi=%0b m_valid=%0b m_last=%0b fir_x=%0d m_data=%0d, want all 0",
               busy, done, s_ready, fir_valid_in, m_valid, m_last, fir_x, m_data);
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%0b s_ready=%0b, want 0 0", busy, s_ready);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int d, tot, span, li, dc, lc, db;
    tot = 8 + FLUSH_LEN;
    drive_frame(8, 1'b0, 1'b0, 1'b1);
    wait_done(400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_done_seen: got 0 want 1"); end
    d = first_diff(sent_q, exp_in_q);
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL basic_fir_x: first diff at %0d, got %0d samples want %0d", d, sent_q.size(), exp_in_q.size());
    end
    span = (sent_cyc.size() > 0) ? sent_cyc[sent_cyc.size()-1] - sent_cyc[0] + 1 : 0;
    n_checks++;
    if (span != tot) begin n_fail++; $display("FAIL basic_valid_in_span: got %0d cycles want %0d", span, tot); end
    d = first_diff(out_q, exp_out_q);
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL basic_m_data: first diff at %0d, got %0d results want %0d", d, out_q.size(), tot);
    end
    li = (last_idx.size() == 1) ? last_idx[0] : -1;
    n_checks++;
    if (li != tot - 1) begin n_fail++; $display("FAIL basic_m_last: got index %0d want %0d", li, tot - 1); end
    dc = (done_cyc.size() == 1) ? done_cyc[0] : -1;
    lc = (last_cyc.size() > 0) ? last_cyc[0] : -99;
    n_checks++;
    if (dc != lc + 1) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want %0d", dc, lc + 1); end
    db = (done_busy.size() > 0) ? done_busy[0] : 1;
    n_checks++;
    if (db != 0) begin n_fail++; $display("FAIL basic_busy_at_done: got %0d want 0", db); end
  endtask

  task automatic test_gaps();
    bit ok;
    int d, tot, li, gap, fspan, sidx;
    tot = 4 + FLUSH_LEN;
    drive_frame(4, 1'b1, 1'b0, 1'b0);
    wait_done(400, ok);
    d = first_diff(sent_q, exp_in_q);
    n_checks++;
    if (!ok || d != -1) begin
      n_fail++;
      $display("FAIL gaps_fir_x: done=%0b first diff at %0d, got %0d samples want %0d", ok, d, sent_q.size(), tot);
    end
    gap = (sent_cyc.size() > 1) ? sent_cyc[1] - sent_cyc[0] : -1;
    n_checks++;
    if (gap != 2) begin n_fail++; $display("FAIL gaps_mirror: got spacing %0d want 2", gap); end
    sidx = sent_cyc.size() - 1 - FLUSH_LEN;
    fspan = (sidx >= 0) ? sent_cyc[sent_cyc.size()-1] - sent_cyc[sidx] : -1;
    n_checks++;
    if (fspan != FLUSH_LEN) begin n_fail++; $display("FAIL gaps_flush_contig: got span %0d want %0d", fspan, FLUSH_LEN); end
    d = first_diff(out_q, exp_out_q);
    li = (last_idx.size() == 1) ? last_idx[0] : -1;
    n_checks++;
    if (d != -1 || li != tot - 1) begin
      n_fail++;
      $display("FAIL gaps_outputs: got %0d results, m_last at %0d, want %0d results m_last at %0d", out_q.size(), li, tot, tot - 1);
    end
  endtask

  task automatic test_zero_len();
    clear_mon();
    @(posedge clock); #1;
    start = 1'b1; frame_len = '0;
    @(posedge clock); #1;
    start = 1'b0;
    n_checks++;
    if ({done, busy, s_ready, fir_valid_in} !== 4'b1000) begin
      n_fail++;
      $display("FAIL zero_len_pulse: done=%0b busy=%0b s_ready=%0b fvi=%0b, want 1 0 0 0", done, busy, s_ready, fir_valid_in);
    end
    @(posedge clock); #1;
    n_checks++;
    if ({done, busy, s_ready} !== 3'b000 || sent_q.size() != 0) begin
      n_fail++;
      $display("FAIL zero_len_after: done=%0b busy=%0b s_ready=%0b samples=%0d, want 0 0 0 0", done, busy, s_ready, sent_q.size());
    end
  endtask

  task automatic test_start_busy();
    bit ok;
    int d, tot, li;
    tot = 5 + FLUSH_LEN;
    drive_frame(5, 1'b0, 1'b1, 1'b0);
    wait_done(400, ok);
    repeat (20) @(posedge clock);
    #1;
    d = first_diff(out_q, exp_out_q);
    li = (last_idx.size() == 1) ? last_idx[0] : -1;
    n_checks++;
    if (!ok || d != -1 || li != tot - 1) begin
      n_fail++;
      $display("FAIL start_busy_outputs: done=%0b got %0d results m_last at %0d, want %0d m_last at %0d", ok, out_q.size(), li, tot, tot - 1);
    end
    n_checks++;
    if (busy !== 1'b0 || done_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL start_busy_ignored: busy=%0b done pulses=%0d, want 0 1", busy, done_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d, tot, li;
    drive_frame(6, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, s_ready, fir_valid_in, m_valid, m_last} !== 6'b0 || fir_x !== '0 || m_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: busy=%0b done=%0b s_ready=%0b fvi=%0b m_valid=%0b m_last=%0b, want all 0",
               busy, done, s_ready, fir_valid_in, m_valid, m_last);
    end
    clear_mon();
    hist.delete();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    n_checks++;
    if (done_cyc.size() != 0 || out_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got %0d done pulses %0d results, want 0 0", done_cyc.size(), out_q.size());
    end
    tot = 2 + FLUSH_LEN;
    drive_frame(2, 1'b0, 1'b0, 1'b0);
    wait_done(400, ok);
    d = first_diff(out_q, exp_out_q);
    li = (last_idx.size() == 1) ? last_idx[0] : -1;
    n_checks++;
    if (!ok || d != -1 || li != tot - 1) begin
      n_fail++;
      $display("FAIL reset_mid_recovery: done=%0b got %0d results m_last at %0d, want %0d m_last at %0d", ok, out_q.size(), li, tot, tot - 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero_len();
    test_start_busy();
    test_reset_mid();
    test_basic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
